// File: rtl/rgb_pwm_pkg.sv
// Shared constants and helpers for the RGB PWM sequencer.
// Optional build macro: RGB_PWM_FADE_EN (see rgb_pwm_channel).
package rgb_pwm_pkg;

    localparam int MAX_CH           = 8;
    localparam int DEFAULT_PWM_BITS = 8;
    localparam int DEFAULT_PRESCALE = 48;

    // Channel index width, kept at least one bit so a single-channel build still has a port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: target/active duty registers, boundary update and compare flop.
// With RGB_PWM_FADE_EN defined, active steps by one toward target at each boundary.
module rgb_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                int_osc,
    input  logic                rstn,
    input  logic                en,
    input  logic                boundary,
    input  logic                wr_sel,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out,
    output logic                pending
);

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] next_active;

    always_comb begin
        // NOTE: default first so every path assigns next_active and no latch is inferred.
        next_active = active;
        if (!en) begin
            next_active = target;
        end else if (boundary) begin
`ifdef RGB_PWM_FADE_EN
            if (active < target) begin
                next_active = active + 1'b1;
            end else if (active > target) begin
                next_active = active - 1'b1;
            end
`else
            next_active = target;
`endif
        end
    end

    // NOTE: duty registers are few and small, so they take the async reset like all other state.
    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            target  <= '0;
            active  <= '0;
            pwm_out <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values (write at a boundary lands one period late).
            if (wr_sel) begin
                target <= wr_duty;
            end
            active  <= next_active;
            pwm_out <= en & (pwm_cnt < active);
        end
    end

    assign pending = (active != target);

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// N-channel PWM sequencer for the SB_RGBA_DRV RGBxPWM inputs.
// Optional build macro: RGB_PWM_FADE_EN enables one-step-per-period duty fading.
module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PWM_BITS = DEFAULT_PWM_BITS,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                        int_osc,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
    input  logic [PWM_BITS-1:0]         wr_duty,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_st,
    output logic                        fading
);

    localparam int CW   = ch_idx_w(NUM_CH);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PS_W-1:0]     prescale;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                boundary;
    logic [NUM_CH-1:0]   pending;

    assign tick     = en && (prescale == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_LAST);

    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            prescale  <= '0;
            pwm_cnt   <= '0;
            period_st <= 1'b0;
            fading    <= 1'b0;
        end else begin
            if (!en) begin
                prescale <= '0;
                pwm_cnt  <= '0;
            end else begin
                prescale <= tick ? '0 : prescale + 1'b1;
                if (tick) begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end
            period_st <= boundary;
            fading    <= |pending;
        end
    end

    // Channel select compares against in-range indices only, so wr_ch >= NUM_CH writes nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .int_osc (int_osc),
            .rstn    (rstn),
            .en      (en),
            .boundary(boundary),
            .wr_sel  (wr_en && (wr_ch == CW'(i))),
            .wr_duty (wr_duty),
            .pwm_cnt (pwm_cnt),
            .pwm_out (pwm_out[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer (NUM_CH=3, PWM_BITS=4, PRESCALE=2).
// Reference model derives the PWM phase arithmetically from the enabled-clock count.
module tb_rgb_pwm_sequencer;

    localparam int NUM_CH   = 3;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int PERIOD   = 1 << PWM_BITS;
    localparam int PCLK     = PERIOD * PRESCALE;
    localparam int CW       = 2;

    logic                int_osc = 1'b0;
    logic                rstn    = 1'b0;
    logic                en      = 1'b0;
    logic                wr_en   = 1'b0;
    logic [CW-1:0]       wr_ch   = '0;
    logic [PWM_BITS-1:0] wr_duty = '0;
    logic [NUM_CH-1:0]   pwm_out;
    logic                period_st;
    logic                fading;

    int checks   = 0;
    int failures = 0;

    always #5 int_osc = ~int_osc;

    rgb_pwm_sequencer #(
        .NUM_CH  (NUM_CH),
        .PWM_BITS(PWM_BITS),
        .PRESCALE(PRESCALE)
    ) dut (
        .int_osc  (int_osc),
        .rstn     (rstn),
        .en       (en),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_duty  (wr_duty),
        .pwm_out  (pwm_out),
        .period_st(period_st),
        .fading   (fading)
    );

    // Reference model state: n = enabled clocks since enable/reset.
    int                n;
    int                m_target[NUM_CH];
    int                m_active[NUM_CH];
    logic [NUM_CH-1:0] e_pwm;
    logic              e_pst;
    logic              e_fad;
    int                hi_cnt[NUM_CH];
    int                pst_cnt;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_target[i] = 0;
            m_active[i] = 0;
        end
    endtask

    function automatic bit converged();
        for (int i = 0; i < NUM_CH; i++)
            if (m_active[i] != m_target[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Predicts what the next clock edge produces from current inputs and model state.
    task automatic model_step();
        int cnt;
        bit bnd;
        cnt   = (n / PRESCALE) % PERIOD;
        bnd   = en && ((n % PCLK) == PCLK - 1);
        e_pst = bnd;
        e_fad = !converged();
        for (int i = 0; i < NUM_CH; i++) begin
            e_pwm[i] = en && (cnt < m_active[i]);
            if (!en) begin
                m_active[i] = m_target[i];
            end else if (bnd) begin
`ifdef RGB_PWM_FADE_EN
                if (m_active[i] < m_target[i]) m_active[i] = m_active[i] + 1;
                else if (m_active[i] > m_target[i]) m_active[i] = m_active[i] - 1;
`else
                m_active[i] = m_target[i];
`endif
            end
        end
        if (wr_en && int'(wr_ch) < NUM_CH) m_target[int'(wr_ch)] = int'(wr_duty);
        n = en ? n + 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge int_osc);
        #1;
        checks += 3;
        if (pwm_out !== e_pwm) begin
            failures++;
            $display("FAIL pwm_out t=%0t got=%b exp=%b", $time, pwm_out, e_pwm);
        end
        if (period_st !== e_pst) begin
            failures++;
            $display("FAIL period_st t=%0t got=%b exp=%b", $time, period_st, e_pst);
        end
        if (fading !== e_fad) begin
            failures++;
            $display("FAIL fading t=%0t got=%b exp=%b", $time, fading, e_fad);
        end
    endtask

    task automatic write(input int ch, input int duty);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_duty = PWM_BITS'(duty);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic check_all_low(input string name);
        checks++;
        if (pwm_out !== '0 || period_st !== 1'b0 || fading !== 1'b0) begin
            failures++;
            $display("FAIL %s got pwm=%b pst=%b fad=%b exp all 0", name, pwm_out, period_st, fading);
        end
    endtask

    // Steps until the cycle after a boundary, i.e. the next edge starts a fresh period.
    task automatic align();
        int g;
        g = 0;
        do begin
            step();
            g++;
        end while (!e_pst && g < PCLK + 1);
        checks++;
        if (period_st !== 1'b1) begin
            failures++;
            $display("FAIL align got period_st=%b exp=1 after %0d clocks", period_st, g);
        end
    endtask

    task automatic settle();
        int g;
        g = 0;
        while (!converged() && g < 40) begin
            align();
            g++;
        end
        checks++;
        if (!converged()) begin
            failures++;
            $display("FAIL settle got unconverged exp converged within %0d periods", g);
        end
    endtask

    task automatic count_period();
        for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
        pst_cnt = 0;
        for (int k = 0; k < PCLK; k++) begin
            step();
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi_cnt[i]++;
            if (period_st) pst_cnt++;
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge int_osc);
        #1;
        check_all_low("reset_state");
        rstn = 1'b1;
        model_reset();
        repeat (4) step();
    endtask

    task automatic test_write_mid_period();
        int g;
        en = 1'b1;
        g  = 0;
        while (((n / PRESCALE) % PERIOD) != 7 && g < PCLK) begin
            step();
            g++;
        end
        write(0, 5);
        align();
        settle();
        count_period();
        expect_int("ch0_high_clocks_duty5", hi_cnt[0], 10);
        expect_int("ch1_high_clocks_idle", hi_cnt[1], 0);
        expect_int("period_st_per_period", pst_cnt, 1);
    endtask

    task automatic test_duty_extremes();
        write(1, 0);
        write(2, 15);
        align();
        settle();
        count_period();
        expect_int("ch1_high_clocks_duty0", hi_cnt[1], 0);
        expect_int("ch2_low_clocks_duty15", PCLK - hi_cnt[2], 2);
        expect_int("period_st_pulses_32clk", pst_cnt, 1);
        count_period();
        expect_int("period_st_pulses_32clk_b", pst_cnt, 1);
    endtask

    task automatic test_boundary_collision();
        int g;
        g = 0;
        while ((n % PCLK) != PCLK - 1 && g < PCLK) begin
            step();
            g++;
        end
        write(0, 9);
        count_period();
        expect_int("collision_old_duty_period", hi_cnt[0], 10);
        count_period();
`ifdef RGB_PWM_FADE_EN
        expect_int("collision_next_period", hi_cnt[0], 12);
`else
        expect_int("collision_next_period", hi_cnt[0], 18);
`endif
        write(3, $urandom_range(0, 15));
        repeat (8) step();
    endtask

    task automatic test_en_toggle();
        int p;
        en = 1'b0;
        repeat (10) begin
            step();
            check_all_low("en_low_outputs");
        end
        en = 1'b1;
        step();
        checks++;
        if (pwm_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL en_restart_rise got=%b exp=1", pwm_out[0]);
        end
        p = 0;
        for (int k = 0; k < PCLK - 2; k++) begin
            step();
            if (period_st) p++;
        end
        expect_int("en_restart_no_period_st", p, 0);
    endtask

    task automatic test_fade();
        write(0, 0);
        align();
        settle();
        repeat (5) step();
        write(0, 4);
        align();
        for (int k = 0; k < 4; k++) begin
            count_period();
`ifdef RGB_PWM_FADE_EN
            expect_int("fade_ramp_high_clocks", hi_cnt[0], 2 * (k + 1));
`else
            expect_int("jump_high_clocks", hi_cnt[0], 8);
`endif
        end
        repeat (3) step();
        checks++;
        if (fading !== 1'b0) begin
            failures++;
            $display("FAIL fading_after_converge got=%b exp=0", fading);
        end
    endtask

    task automatic test_reset_midrun();
        int g;
        g = 0;
        do begin
            step();
            g++;
        end while (e_pwm == '0 && g < PCLK);
        #2;
        rstn = 1'b0;
        #1;
        check_all_low("async_reset_immediate");
        repeat (3) begin
            @(posedge int_osc);
            #1;
            check_all_low("reset_held");
        end
        rstn = 1'b1;
        model_reset();
        repeat (PCLK) step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = CW'($urandom_range(0, 3));
                wr_duty = PWM_BITS'($urandom_range(0, 15));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_mid_period();
        test_duty_extremes();
        test_boundary_collision();
        test_en_toggle();
        test_fade();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
